// File: rtl/branch_resolve.sv
// Branch resolution stage: derives Z/N/C/V from ALU output, evaluates the branch
// condition and produces taken/target through a 2-stage valid/ready pipeline.
module branch_resolve #(
   parameter int WIDTH     = 32,
   parameter int PC_WIDTH  = 32,
   parameter int IMM_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     result,
   input  logic                 carryout,
   input  logic                 overflow,
   input  logic [2:0]           br_op,
   input  logic [PC_WIDTH-1:0]  pc,
   input  logic [IMM_WIDTH-1:0] imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 taken,
   output logic [PC_WIDTH-1:0]  target,
   output logic [3:0]           flags
);

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BLT  = 3'd3,
      BR_BGE  = 3'd4,
      BR_BLTU = 3'd5,
      BR_BGEU = 3'd6,
      BR_JMP  = 3'd7
   } br_op_e;

   logic                 s1_v_q, s1_v_d;
   logic [WIDTH-1:0]     s1_result_q, s1_result_d;
   logic                 s1_carry_q, s1_carry_d;
   logic                 s1_ovf_q, s1_ovf_d;
   br_op_e               s1_op_q, s1_op_d;
   logic [PC_WIDTH-1:0]  s1_pc_q, s1_pc_d;
   logic [IMM_WIDTH-1:0] s1_imm_q, s1_imm_d;

   logic                 s2_v_q, s2_v_d;
   logic                 taken_q, taken_d;
   logic [PC_WIDTH-1:0]  target_q, target_d;
   logic [3:0]           flags_q, flags_d;

   logic                 s1_adv, s2_adv;
   logic                 flag_z, flag_n, cond;
   logic [PC_WIDTH-1:0]  offset;

   // Each stage advances when empty or when the stage after it is advancing.
   assign s2_adv   = !s2_v_q || out_ready;
   assign s1_adv   = !s1_v_q || s2_adv;
   assign in_ready = s1_adv;

   always_comb begin
      s1_v_d      = s1_v_q;
      s1_result_d = s1_result_q;
      s1_carry_d  = s1_carry_q;
      s1_ovf_d    = s1_ovf_q;
      s1_op_d     = s1_op_q;
      s1_pc_d     = s1_pc_q;
      s1_imm_d    = s1_imm_q;
      if (s1_adv) begin
         s1_v_d = in_valid;
         if (in_valid) begin
            s1_result_d = result;
            s1_carry_d  = carryout;
            s1_ovf_d    = overflow;
            s1_op_d     = br_op_e'(br_op);
            s1_pc_d     = pc;
            s1_imm_d    = imm;
         end
      end
   end

   always_comb begin
      flag_z = ~|s1_result_q;
      flag_n = s1_result_q[WIDTH-1];
      case (s1_op_q)
         BR_BEQ:  cond = flag_z;
         BR_BNE:  cond = !flag_z;
         BR_BLT:  cond = flag_n ^ s1_ovf_q;
         BR_BGE:  cond = !(flag_n ^ s1_ovf_q);
         BR_BLTU: cond = !s1_carry_q;
         BR_BGEU: cond = s1_carry_q;
         BR_JMP:  cond = 1'b1;
         default: cond = 1'b0;
      endcase
      offset = PC_WIDTH'($signed(s1_imm_q)) << 2;

      s2_v_d   = s2_v_q;
      taken_d  = taken_q;
      target_d = target_q;
      flags_d  = flags_q;
      if (s2_adv) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            taken_d  = cond;
            target_d = cond ? (s1_pc_q + offset) : (s1_pc_q + PC_WIDTH'(4));
            flags_d  = {flag_z, flag_n, s1_carry_q, s1_ovf_q};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q      <= 1'b0;
         s1_result_q <= '0;
         s1_carry_q  <= 1'b0;
         s1_ovf_q    <= 1'b0;
         s1_op_q     <= BR_NONE;
         s1_pc_q     <= '0;
         s1_imm_q    <= '0;
         s2_v_q      <= 1'b0;
         taken_q     <= 1'b0;
         target_q    <= '0;
         flags_q     <= '0;
      end else begin
         s1_v_q      <= s1_v_d;
         s1_result_q <= s1_result_d;
         s1_carry_q  <= s1_carry_d;
         s1_ovf_q    <= s1_ovf_d;
         s1_op_q     <= s1_op_d;
         s1_pc_q     <= s1_pc_d;
         s1_imm_q    <= s1_imm_d;
         s2_v_q      <= s2_v_d;
         taken_q     <= taken_d;
         target_q    <= target_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid = s2_v_q;
   assign taken     = taken_q;
   assign target    = target_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed cases plus random traffic against a
// queue-based reference model of accepted ops.
module tb_branch_resolve;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] result;
   logic        carryout, overflow;
   logic [2:0]  br_op;
   logic [31:0] pc;
   logic [15:0] imm;
   logic        out_valid, out_ready, taken;
   logic [31:0] target;
   logic [3:0]  flags;

   always #5 clk = ~clk;

   branch_resolve #(.WIDTH(32), .PC_WIDTH(32), .IMM_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .result(result), .carryout(carryout), .overflow(overflow), .br_op(br_op),
      .pc(pc), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
      .taken(taken), .target(target), .flags(flags)
   );

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic [3:0]  flags;
   } exp_t;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned n_accepted = 0;
   exp_t        exp_q[$];
   logic [3:0]  last_flags = 4'b0000;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] res, input logic c, input logic v,
                                  input logic [2:0] op, input logic [31:0] p,
                                  input logic [15:0] im);
      exp_t m;
      bit   z = (res == 32'd0);
      bit   n = res[31];
      bit   tk;
      int   off;
      case (op)
         3'd0: tk = 1'b0;
         3'd1: tk = z;
         3'd2: tk = !z;
         3'd3: tk = (n != v);
         3'd4: tk = (n == v);
         3'd5: tk = !c;
         3'd6: tk = c;
         default: tk = 1'b1;
      endcase
      off = int'($signed(im));
      m.taken  = tk;
      m.target = tk ? p + 32'(off * 4) : p + 32'd4;
      m.flags  = {z, n, c, v};
      return m;
   endfunction

   // Scoreboard: pop on delivery, push on acceptance; both sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 64'(out_valid), 64'(0));
            end else begin
               check("taken", 64'(taken), 64'(exp_q[0].taken));
               check("target", 64'(target), 64'(exp_q[0].target));
               check("flags", 64'(flags), 64'(exp_q[0].flags));
               if (out_ready) begin
                  last_flags = exp_q[0].flags;
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            check("flags_idle", 64'(flags), 64'(last_flags));
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(result, carryout, overflow, br_op, pc, imm));
            n_accepted++;
         end
      end
   end

   task automatic send(input logic [31:0] res, input logic c, input logic v,
                       input logic [2:0] op, input logic [31:0] p, input logic [15:0] im);
      bit ok = 1'b0;
      in_valid = 1'b1; result = res; carryout = c; overflow = v;
      br_op = op; pc = p; imm = im;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) check("send_timeout", 64'(ok), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic directed(input string tag, input logic [31:0] res, input logic c,
                           input logic v, input logic [2:0] op, input logic [31:0] p,
                           input logic [15:0] im, input logic exp_tk,
                           input logic [31:0] exp_tg, input logic [3:0] exp_fl);
      send(res, c, v, op, p, im);
      @(negedge clk);
      check({tag, "_early"}, 64'(out_valid), 64'(0));
      @(negedge clk);
      check({tag, "_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_taken"}, 64'(taken), 64'(exp_tk));
      check({tag, "_target"}, 64'(target), 64'(exp_tg));
      check({tag, "_flags"}, 64'(flags), 64'(exp_fl));
      @(posedge clk); #1;
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      check(tag, 64'(exp_q.size()), 64'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      int unsigned acc0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      result = '0; carryout = 1'b0; overflow = 1'b0; br_op = '0; pc = '0; imm = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_flags", 64'(flags), 64'(0));
      check("rst_taken", 64'(taken), 64'(0));
      check("rst_target", 64'(target), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;

      directed("beq_z",    32'h0,         1'b0, 1'b0, 3'd1, 32'h100,      16'd4,
               1'b1, 32'h110, 4'b1000);
      directed("bne_nz",   32'h1,         1'b0, 1'b0, 3'd2, 32'h100,      16'hFFFE,
               1'b1, 32'hF8, 4'b0000);
      directed("beq_nz",   32'h1,         1'b0, 1'b0, 3'd1, 32'h100,      16'hFFFE,
               1'b0, 32'h104, 4'b0000);
      directed("blt_v0",   32'h8000_0000, 1'b0, 1'b0, 3'd3, 32'h200,      16'd3,
               1'b1, 32'h20C, 4'b0100);
      directed("blt_v1",   32'h8000_0000, 1'b0, 1'b1, 3'd3, 32'h200,      16'd3,
               1'b0, 32'h204, 4'b0101);
      directed("bgeu_c1",  32'h5,         1'b1, 1'b0, 3'd6, 32'h300,      16'd2,
               1'b1, 32'h308, 4'b0010);
      directed("jmp_wrap", 32'h7,         1'b0, 1'b0, 3'd7, 32'hFFFF_FFFC, 16'd1,
               1'b1, 32'h0, 4'b0000);
      directed("none_z",   32'h0,         1'b0, 1'b0, 3'd0, 32'h400,      16'd8,
               1'b0, 32'h404, 4'b1000);

      // Backpressure: five back-to-back ops while the consumer stalls four cycles.
      out_ready = 1'b0;
      acc0 = n_accepted;
      fork
         begin
            for (int i = 0; i < 5; i++)
               send(32'(i + 1), 1'b0, 1'b0, 3'd7, 32'h1000 + 32'(i * 16), 16'(i));
         end
         begin
            repeat (4) @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_accepted", 64'(n_accepted - acc0), 64'(2));
            check("bp_out_valid", 64'(out_valid), 64'(1));
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      wait_drain("bp_drain");
      check("bp_total", 64'(n_accepted - acc0), 64'(5));

      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (i == 200) begin
            @(negedge clk); #2;
            rst_n = 1'b0;
            #1;
            check("mid_rst_out_valid", 64'(out_valid), 64'(0));
            check("mid_rst_flags", 64'(flags), 64'(0));
            exp_q.delete();
            last_flags = 4'b0000;
            in_valid = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            check("mid_rst_in_ready", 64'(in_ready), 64'(1));
            check("mid_rst_no_out", 64'(out_valid), 64'(0));
            @(posedge clk); #1;
         end
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 3))
            0:       result = 32'h0;
            1:       result = 32'h8000_0000 | $urandom;
            default: result = $urandom;
         endcase
         carryout = 1'($urandom);
         overflow = 1'($urandom);
         br_op    = 3'($urandom);
         pc       = $urandom;
         imm      = 16'($urandom);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain("rand_drain");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
